// File: rtl/ps2_key_display.sv
// PS/2 device-to-host receiver with power-up hold-off, last-byte latch and two-digit hex readout.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits do not hold an odd count of 1s.
module ps2_key_display #(
  parameter int unsigned RST_DELAY_CYCLES = 20'hFFFFF,
  parameter int unsigned TIMEOUT_CYCLES   = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi,
  output logic       reset_done
);

  localparam int unsigned DlyW = (RST_DELAY_CYCLES > 0) ? $clog2(RST_DELAY_CYCLES + 1) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DlyW-1:0] DlyMax = DlyW'(RST_DELAY_CYCLES);
  localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT_CYCLES);

  logic            clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [DlyW-1:0] dly_q, dly_d;
  logic            reset_done_q, reset_done_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_q, stop_d;
  logic            frame_q, frame_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            pressed_q, pressed_d;
  logic [7:0]      key_q, key_d, out_q, out_d;
  logic            fall;
  logic            parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    dly_d        = dly_q;
    reset_done_d = reset_done_q;
    if (dly_q != DlyMax) dly_d = dly_q + 1'b1;
    if (dly_d == DlyMax) reset_done_d = 1'b1;
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
    frame_d   = 1'b0;
    to_d      = '0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (!reset_done_q) begin
      bit_cnt_d = 4'd0;
    end else if (fall) begin
      if (bit_cnt_q == 4'd0) begin
        // A start bit of 1 leaves the receiver idle.
        if (!dat_s2_q) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
        par_d     = dat_s2_q;
`endif
        bit_cnt_d = 4'd10;
      end else begin
        stop_d    = dat_s2_q;
        frame_d   = 1'b1;
        bit_cnt_d = 4'd0;
      end
    end else if (bit_cnt_q != 4'd0 && clk_s2_q) begin
      to_d = to_q + 1'b1;
      if (to_d == ToMax) begin
        bit_cnt_d = 4'd0;
        to_d      = '0;
      end
    end
  end

  always_comb begin
    pressed_d = 1'b0;
    key_d     = key_q;
    out_d     = out_q;
    if (frame_q && stop_q && parity_ok) begin
      pressed_d = 1'b1;
      key_d     = shift_q;
      out_d     = shift_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Lines idle high, so syncs reset high to avoid a phantom fall.
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      dly_q        <= '0;
      reset_done_q <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      stop_q       <= 1'b0;
      frame_q      <= 1'b0;
      to_q         <= '0;
      pressed_q    <= 1'b0;
      key_q        <= 8'h00;
      out_q        <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      clk_s1_q     <= ps2_clock;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      dly_q        <= dly_d;
      reset_done_q <= reset_done_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      stop_q       <= stop_d;
      frame_q      <= frame_d;
      to_q         <= to_d;
      pressed_q    <= pressed_d;
      key_q        <= key_d;
      out_q        <= out_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign ps2_key_data    = key_q;
  assign ps2_key_pressed = pressed_q;
  assign ps2_out         = out_q;
  assign reset_done      = reset_done_q;
  assign seg_lo          = hex7(out_q[3:0]);
  assign seg_hi          = hex7(out_q[7:4]);

endmodule

// File: tb/tb_ps2_key_display.sv
// Randomised PS/2 frame stimulus with a frame-level reference model and a pulse scoreboard.
module tb_ps2_key_display;

  localparam int unsigned RstDly  = 16;
  localparam int unsigned Timeout = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_key_data, ps2_out;
  logic       ps2_key_pressed, reset_done;
  logic [6:0] seg_lo, seg_hi;

  ps2_key_display #(
    .RST_DELAY_CYCLES(RstDly),
    .TIMEOUT_CYCLES  (Timeout)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clock      (ps2_clock),
    .ps2_data       (ps2_data),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_out        (ps2_out),
    .seg_lo         (seg_lo),
    .seg_hi         (seg_hi),
    .reset_done     (reset_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses_exp = 0;
  int         pulses_seen = 0;
  logic [7:0] model_out = 8'h00;

  initial forever @(posedge clock) cyc++;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expected frame, including its latency.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (ps2_key_pressed) begin
        pulses_seen++;
        check("pulse_width", {31'd0, prev}, 32'd0);
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_pulse: got byte %0h expected no pulse", ps2_key_data);
        end else begin
          e = sb.pop_front();
          check("key_data", {24'd0, ps2_key_data}, {24'd0, e.b});
          check("out_at_pulse", {24'd0, ps2_out}, {24'd0, e.b});
          check("latency", cyc, e.at);
          check("seg_lo", {25'd0, seg_lo}, {25'd0, seg_of(e.b[3:0])});
          check("seg_hi", {25'd0, seg_hi}, {25'd0, seg_of(e.b[7:4])});
        end
      end
      prev = ps2_key_pressed;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends the first nbits of a frame; expectation is pushed at the stop-bit fall.
  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_start,
                            input bit bad_par, input bit bad_stop, input bit live);
    logic [10:0] bits;
    bit          good;
    bits = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
`ifdef PS2_PARITY_CHECK_EN
    good = !bad_par;
`else
    good = 1'b1;
`endif
    good = good && !bad_stop && !bad_start && (nbits == 11) && live;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_data = bits[i];
      idle(4);
      ps2_clock = 1'b0;
      if (i == 10 && good) begin
        sb.push_back('{b, cyc + 4});
        model_out = b;
        pulses_exp++;
      end
      idle(20);
      ps2_clock = 1'b1;
      idle(15);
    end
    ps2_data = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(3);
    check("rst_key_data", {24'd0, ps2_key_data}, 32'd0);
    check("rst_out", {24'd0, ps2_out}, 32'd0);
    check("rst_pressed", {31'd0, ps2_key_pressed}, 32'd0);
    check("rst_done", {31'd0, reset_done}, 32'd0);
    check("rst_seg_lo", {25'd0, seg_lo}, 32'h40);
    check("rst_seg_hi", {25'd0, seg_hi}, 32'h40);
    reset = 1'b0;
    model_out = 8'h00;
  endtask

  task automatic wait_done();
    idle(RstDly - 1);
    check("done_early", {31'd0, reset_done}, 32'd0);
    idle(1);
    check("done_on_time", {31'd0, reset_done}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int         r, n;

    do_reset();
    wait_done();
    idle(20);
    check("done_sticky", {31'd0, reset_done}, 32'd1);

    // Frame during hold-off is ignored; the tail must time out without output.
    do_reset();
    send_frame(8'h55, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(100);
    check("holdoff_out", {24'd0, ps2_out}, 32'd0);

    send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("out_1c", {24'd0, ps2_out}, {24'd0, model_out});
    check("seg_lo_1c", {25'd0, seg_lo}, 32'h46);
    check("seg_hi_1c", {25'd0, seg_hi}, 32'h79);

    send_frame(8'hF0, 11, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(5);
    check("out_f0_badpar", {24'd0, ps2_out}, {24'd0, model_out});

    send_frame(8'h3A, 11, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(5);
    check("out_bad_stop", {24'd0, ps2_out}, {24'd0, model_out});

    send_frame(8'h77, 11, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(100);
    check("out_bad_start", {24'd0, ps2_out}, {24'd0, model_out});

    send_frame(8'hC3, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(Timeout);
    send_frame(8'h5A, 11, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("out_after_timeout", {24'd0, ps2_out}, 32'h5A);

    send_frame(8'hB2, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    wait_done();
    send_frame(8'h29, 11, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("out_after_reset", {24'd0, ps2_out}, 32'h29);

    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      r = $urandom_range(0, 15);
      n = (r == 5) ? $urandom_range(2, 10) : 11;
      send_frame(b, n, r == 4, r < 3, r == 3, 1'b1);
      if (r == 4 || r == 5) idle(80);
      else idle($urandom_range(0, 6));
      check("rand_out", {24'd0, ps2_out}, {24'd0, model_out});
    end

    idle(20);
    check("queue_empty", sb.size(), 32'd0);
    check("pulse_count", pulses_seen, pulses_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
